// File: rtl/seq_divider_pkg.sv
// Shared ALU package: datapath width, divider states and helpers.
// Imported by the divider and its step datapath.
package seq_divider_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_t;

  function automatic logic [DATA_W-1:0] abs32(
    input logic [DATA_W-1:0] v
  );
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore the remainder.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   r,
  input  logic         q_msb,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic         q_bit
);

  logic [W+1:0] r_sh;
  logic [W+1:0] t;
  logic         neg;

  assign r_sh   = {r, q_msb};
  assign t      = r_sh - {2'b00, d};
  assign neg    = t[W+1];
  assign q_bit  = ~neg;
  assign r_next = neg ? r_sh[W:0] : t[W:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, one quotient bit per clock.
// Quotient on Zlowout, remainder on Zhighout.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Zlowout,
  output logic [WIDTH-1:0] Zhighout
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_next;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             q_bit;

  div_step #(
    .W(WIDTH)
  ) u_step (
    .r      (r),
    .q_msb  (q[WIDTH-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      q        <= '0;
      d        <= '0;
      r        <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      Zlowout  <= '0;
      Zhighout <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // The done cycle still counts as busy; starts are dropped.
          if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
          end else if (start) begin
            busy   <= 1'b1;
            r      <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r <= a[WIDTH-1];
            d      <= abs32(b);
            if (b == '0) begin
              q     <= a;
              state <= FIX;
            end else begin
              q     <= abs32(a);
              state <= RUN;
            end
          end
        end
        RUN: begin
          r   <= r_next;
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          // d is zero only for a zero divisor; q then holds raw a.
          if (d == '0) begin
            Zlowout  <= '1;
            Zhighout <= q;
            div_zero <= 1'b1;
          end else begin
            Zlowout  <= sign_q ? -q : q;
            Zhighout <= sign_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
            div_zero <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
